// File: rtl/sifh_readout_pkg.sv
// rtl/sifh_readout_pkg.sv - shared types and defaults for the SiFH peak readout path
//
// Purpose: FSM state encoding, index-width helper and default geometry constants
// used by the peak readout serializer.

package sifh_readout_pkg;

   // Default geometry, aligned with the histogram builder / peak detector.
   localparam int DEFAULT_NP        = 12;
   localparam int DEFAULT_PIXEL_NUM = 200;
   localparam int DEFAULT_FID_W     = 8;

   // CSUM is only reachable when the checksum beat is built in.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      CSUM   = 2'd2
   } state_e;

   // Index width wide enough to also hold the sentinel value n (checksum beat index).
   function automatic int idx_width(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/peak_readout_serializer.sv
// rtl/peak_readout_serializer.sv - snapshots per-pixel peaks and streams them one beat per pixel
//
// Purpose: on a frame-done strobe, captures the flattened peak bus and streams it
// out over a valid/ready handshake, tagging each beat with pixel index and frame id.
// Loads arriving while busy are dropped and flagged in a sticky overrun bit.
// Optional macro PEAK_READOUT_CHECKSUM_EN appends a modulo-2^NP checksum beat.
//
// Ports:
//   clk          in   system clock, rising edge
//   res          in   asynchronous active-low reset
//   load         in   single-cycle frame-done strobe
//   peak_in      in   flattened peaks, pixel k at [k*NP +: NP]
//   out_ready    in   consumer ready
//   overrun_clr  in   clears the sticky overrun flag
//   out_valid    out  beat valid
//   out_data     out  peak value (or checksum) of the current beat
//   out_pix_idx  out  pixel index of the current beat
//   out_first    out  first beat of the frame
//   out_last     out  final beat of the frame
//   out_fid      out  frame id of the frame being streamed
//   busy         out  high whenever not IDLE
//   overrun      out  sticky: a load was dropped

module peak_readout_serializer
   import sifh_readout_pkg::*;
#(
   parameter int NP        = DEFAULT_NP,
   parameter int PIXEL_NUM = DEFAULT_PIXEL_NUM,
   parameter int IDX_W     = idx_width(PIXEL_NUM),
   parameter int FID_W     = DEFAULT_FID_W
) (
   input  logic                    clk,
   input  logic                    res,
   input  logic                    load,
   input  logic [PIXEL_NUM*NP-1:0] peak_in,
   input  logic                    out_ready,
   input  logic                    overrun_clr,
   output logic                    out_valid,
   output logic [NP-1:0]           out_data,
   output logic [IDX_W-1:0]        out_pix_idx,
   output logic                    out_first,
   output logic                    out_last,
   output logic [FID_W-1:0]        out_fid,
   output logic                    busy,
   output logic                    overrun
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PIXEL_NUM - 1);

   state_e                  state_q, state_d;
   logic [IDX_W-1:0]        index_q, index_d;
   logic [FID_W-1:0]        fid_q, fid_d;
   logic [PIXEL_NUM*NP-1:0] snap_q, snap_d;
   logic                    overrun_q, overrun_d;
   logic [NP-1:0]           pix_sel;

`ifdef PEAK_READOUT_CHECKSUM_EN
   localparam logic [IDX_W-1:0] CSUM_IDX = IDX_W'(PIXEL_NUM);
   logic [NP-1:0]           csum_q, csum_d;
`endif

   // Pixel mux over the snapshot; compare-based so the index never selects past the bank.
   always_comb begin
      pix_sel = '0;
      for (int k = 0; k < PIXEL_NUM; k++) begin
         if (index_q == IDX_W'(k)) begin
            pix_sel = snap_q[k*NP +: NP];
         end
      end
   end

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         state_q   <= IDLE;
         index_q   <= '0;
         fid_q     <= '0;
         snap_q    <= '0;
         overrun_q <= 1'b0;
`ifdef PEAK_READOUT_CHECKSUM_EN
         csum_q    <= '0;
`endif
      end else begin
         state_q   <= state_d;
         index_q   <= index_d;
         fid_q     <= fid_d;
         snap_q    <= snap_d;
         overrun_q <= overrun_d;
`ifdef PEAK_READOUT_CHECKSUM_EN
         csum_q    <= csum_d;
`endif
      end
   end

   always_comb begin
      state_d     = state_q;
      index_d     = index_q;
      fid_d       = fid_q;
      snap_d      = snap_q;
      overrun_d   = overrun_q;
`ifdef PEAK_READOUT_CHECKSUM_EN
      csum_d      = csum_q;
`endif
      out_valid   = 1'b0;
      out_data    = '0;
      out_pix_idx = '0;
      out_first   = 1'b0;
      out_last    = 1'b0;

      case (state_q)
         IDLE: begin
            if (load) begin
               snap_d  = peak_in;
               index_d = '0;
               fid_d   = fid_q + FID_W'(1);
               state_d = STREAM;
`ifdef PEAK_READOUT_CHECKSUM_EN
               csum_d  = '0;
`endif
            end
         end

         STREAM: begin
            out_valid   = 1'b1;
            out_data    = pix_sel;
            out_pix_idx = index_q;
            out_first   = (index_q == '0);
`ifdef PEAK_READOUT_CHECKSUM_EN
            out_last    = 1'b0;
`else
            out_last    = (index_q == LAST_IDX);
`endif
            if (out_ready) begin
`ifdef PEAK_READOUT_CHECKSUM_EN
               // Accumulate on transfer so the checksum beat is already stable.
               csum_d = csum_q + pix_sel;
`endif
               if (index_q == LAST_IDX) begin
`ifdef PEAK_READOUT_CHECKSUM_EN
                  index_d = CSUM_IDX;
                  state_d = CSUM;
`else
                  state_d = IDLE;
`endif
               end else begin
                  index_d = index_q + IDX_W'(1);
               end
            end
         end

`ifdef PEAK_READOUT_CHECKSUM_EN
         CSUM: begin
            out_valid   = 1'b1;
            out_data    = csum_q;
            out_pix_idx = index_q;
            out_last    = 1'b1;
            if (out_ready) begin
               state_d = IDLE;
            end
         end
`endif

         default: state_d = IDLE;
      endcase

      // A drop outranks a clear in the same cycle.
      if (load && (state_q != IDLE)) begin
         overrun_d = 1'b1;
      end else if (overrun_clr) begin
         overrun_d = 1'b0;
      end
   end

   assign out_fid = fid_q;
   assign busy    = (state_q != IDLE);
   assign overrun = overrun_q;

endmodule

// File: tb/tb_peak_readout_serializer.sv
// tb/tb_peak_readout_serializer.sv - directed self-checking bench for peak_readout_serializer

module tb_peak_readout_serializer;

   localparam int NP        = 12;
   localparam int PIXEL_NUM = 4;
   localparam int IDX_W     = 3;
   localparam int FID_W     = 8;

   logic                    clk;
   logic                    res;
   logic                    load;
   logic [PIXEL_NUM*NP-1:0] peak_in;
   logic                    out_ready;
   logic                    overrun_clr;
   logic                    out_valid;
   logic [NP-1:0]           out_data;
   logic [IDX_W-1:0]        out_pix_idx;
   logic                    out_first;
   logic                    out_last;
   logic [FID_W-1:0]        out_fid;
   logic                    busy;
   logic                    overrun;

   int checks;
   int failures;

   logic [NP-1:0] pk [PIXEL_NUM];
   logic [PIXEL_NUM*NP-1:0] frame_a;
   logic [PIXEL_NUM*NP-1:0] frame_b;

   peak_readout_serializer #(
      .NP(NP), .PIXEL_NUM(PIXEL_NUM), .IDX_W(IDX_W), .FID_W(FID_W)
   ) dut (
      .clk(clk), .res(res), .load(load), .peak_in(peak_in),
      .out_ready(out_ready), .overrun_clr(overrun_clr),
      .out_valid(out_valid), .out_data(out_data), .out_pix_idx(out_pix_idx),
      .out_first(out_first), .out_last(out_last), .out_fid(out_fid),
      .busy(busy), .overrun(overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_beat(input int i, input int fid);
      check($sformatf("valid[%0d]", i), 32'(out_valid), 32'd1);
      check($sformatf("idx[%0d]", i),   32'(out_pix_idx), 32'(i));
      check($sformatf("data[%0d]", i),  32'(out_data), 32'(pk[i]));
      check($sformatf("first[%0d]", i), 32'(out_first), 32'(i == 0));
`ifdef PEAK_READOUT_CHECKSUM_EN
      check($sformatf("last[%0d]", i),  32'(out_last), 32'd0);
`else
      check($sformatf("last[%0d]", i),  32'(out_last), 32'(i == PIXEL_NUM - 1));
`endif
      check($sformatf("fid[%0d]", i),   32'(out_fid), 32'(fid));
   endtask

   // Moves from the last pixel beat to the final beat of the frame (no-op without checksum).
   task automatic step_to_final(input int fid);
`ifdef PEAK_READOUT_CHECKSUM_EN
      tick();
      check("csum_valid", 32'(out_valid), 32'd1);
      check("csum_idx",   32'(out_pix_idx), 32'(PIXEL_NUM));
      check("csum_data",  32'(out_data), 32'h05F);
      check("csum_first", 32'(out_first), 32'd0);
      check("csum_last",  32'(out_last), 32'd1);
      check("csum_fid",   32'(out_fid), 32'(fid));
      check("csum_busy",  32'(busy), 32'd1);
`else
      check("final_fid",  32'(out_fid), 32'(fid));
`endif
   endtask

   task automatic check_idle_zero(input string tag);
      check({tag, "_valid"}, 32'(out_valid), 32'd0);
      check({tag, "_busy"},  32'(busy), 32'd0);
      check({tag, "_data"},  32'(out_data), 32'd0);
      check({tag, "_idx"},   32'(out_pix_idx), 32'd0);
      check({tag, "_first"}, 32'(out_first), 32'd0);
      check({tag, "_last"},  32'(out_last), 32'd0);
      check({tag, "_fid"},   32'(out_fid), 32'd0);
      check({tag, "_ovr"},   32'(overrun), 32'd0);
   endtask

   initial begin
      checks      = 0;
      failures    = 0;
      pk[0]       = 12'h010;
      pk[1]       = 12'h020;
      pk[2]       = 12'h030;
      pk[3]       = 12'hFFF;
      frame_a     = {pk[3], pk[2], pk[1], pk[0]};
      frame_b     = {4{12'hAAA}};
      res         = 1'b0;
      load        = 1'b0;
      peak_in     = frame_a;
      out_ready   = 1'b1;
      overrun_clr = 1'b0;

      // Reset state
      tick();
      tick();
      check_idle_zero("rst");
      res = 1'b1;
      tick();
      check_idle_zero("post_rst");

      // Basic frame: fid 1
      load = 1'b1;
      tick();
      load = 1'b0;
      for (int i = 0; i < PIXEL_NUM; i++) begin
         check_beat(i, 1);
         if (i < PIXEL_NUM - 1) tick();
      end
      step_to_final(1);
      tick();
      check("basic_busy_end",  32'(busy), 32'd0);
      check("basic_valid_end", 32'(out_valid), 32'd0);

      // Backpressure at idx1: fid 2
      load = 1'b1;
      tick();
      load = 1'b0;
      check_beat(0, 2);
      tick();
      out_ready = 1'b0;
      for (int s = 0; s < 3; s++) begin
         check_beat(1, 2);
         tick();
      end
      out_ready = 1'b1;
      check_beat(1, 2);
      tick();
      check_beat(2, 2);
      tick();
      check_beat(3, 2);
      step_to_final(2);
      tick();
      check("bp_busy_end", 32'(busy), 32'd0);

      // Overrun: dropped load at idx2 with different peaks, fid 3
      load = 1'b1;
      tick();
      load = 1'b0;
      check_beat(0, 3);
      tick();
      check_beat(1, 3);
      tick();
      check_beat(2, 3);
      peak_in = frame_b;
      load    = 1'b1;
      tick();
      load    = 1'b0;
      check("ovr_set", 32'(overrun), 32'd1);
      check_beat(3, 3);
      step_to_final(3);
      tick();
      check("ovr_busy_end", 32'(busy), 32'd0);
      check("ovr_sticky",   32'(overrun), 32'd1);
      peak_in = frame_a;

      // Clear and drop in the same cycle: set wins. fid 4
      load = 1'b1;
      tick();
      check_beat(0, 4);
      overrun_clr = 1'b1;
      tick();
      load = 1'b0;
      check("ovr_set_wins", 32'(overrun), 32'd1);
      check_beat(1, 4);
      tick();
      overrun_clr = 1'b0;
      check("ovr_cleared", 32'(overrun), 32'd0);
      check_beat(2, 4);
      tick();
      check_beat(3, 4);
      step_to_final(4);
      tick();

      // Back-to-back: load the cycle right after the final transfer is accepted, fid 5
      load = 1'b1;
      tick();
      load = 1'b0;
      check_beat(0, 5);
      tick();
      check_beat(1, 5);
      tick();
      check_beat(2, 5);
      tick();
      check_beat(3, 5);
      step_to_final(5);
      // Load coincident with the final transfer is dropped
      load = 1'b1;
      tick();
      load = 1'b0;
      check("b2b_busy",    32'(busy), 32'd0);
      check("b2b_ovr",     32'(overrun), 32'd1);
      check("b2b_fid",     32'(out_fid), 32'd5);
      overrun_clr = 1'b1;
      tick();
      overrun_clr = 1'b0;
      check("b2b_ovr_clr", 32'(overrun), 32'd0);

      // Reset mid-stream at idx2, fid 6
      load = 1'b1;
      tick();
      load = 1'b0;
      check_beat(0, 6);
      tick();
      tick();
      check_beat(2, 6);
      res = 1'b0;
      #1;
      check_idle_zero("mid_rst");
      @(posedge clk);
      #1;
      res = 1'b1;
      check_idle_zero("mid_rst_hold");
      load = 1'b1;
      tick();
      load = 1'b0;
      for (int i = 0; i < PIXEL_NUM; i++) begin
         check_beat(i, 1);
         if (i < PIXEL_NUM - 1) tick();
      end
      step_to_final(1);
      tick();
      check("rst_frame_busy_end", 32'(busy), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/peak_readout_serializer.md
Name: peak_readout_serializer

Overview:
- Downstream neighbour of the histogram builder / peak detector in the SiFH dToF pipeline.
- On a frame-done strobe it snapshots the per-pixel peak results, which arrive as a flattened parallel bus.
- It then streams them out one pixel per beat over a valid/ready handshake to the readout interface, tagging each beat with pixel index and frame id.
- Frames that arrive while streaming is still in progress are dropped and flagged.

Parameters:
- NP, 12, peak/timestamp word width (matches Np).
- PIXEL_NUM, 200, pixels per RAM (matches PIXEL_NUM_PER_RAM).
- IDX_W, $clog2(PIXEL_NUM+1), pixel-index width; includes the sentinel value PIXEL_NUM.
- FID_W, 8, frame-id counter width.

Ports:
- clk  in  1  system clock, rising edge.
- res  in  1  asynchronous active-low reset.
- load  in  1  single-cycle frame-done strobe from the peak detector.
- peak_in  in  PIXEL_NUM*NP  flattened peaks; pixel k is at [k*NP +: NP].
- out_ready  in  1  consumer ready.
- overrun_clr  in  1  clears the sticky overrun flag.
- out_valid  out  1  beat valid.
- out_data  out  NP  peak value of the current beat.
- out_pix_idx  out  IDX_W  pixel index of the current beat.
- out_first  out  1  first beat of the frame.
- out_last  out  1  final beat of the frame.
- out_fid  out  FID_W  frame id of the frame being streamed.
- busy  out  1  high in any state other than IDLE.
- overrun  out  1  sticky: a load was dropped.

Behaviour:
- Reset (res low, asynchronous):
  - State goes to IDLE; snapshot registers, index and frame id are cleared to 0.
  - All outputs go to 0.
  - Reset taken mid-stream aborts the frame with no further beats.
- Handshake:
  - A beat transfers on a rising edge where out_valid and out_ready are both high.
  - While out_valid=1 and out_ready=0, out_data, out_pix_idx, out_first, out_last and out_fid hold stable.
  - out_valid never drops without a transfer.
- State IDLE:
  - out_valid=0, busy=0.
  - load=1: capture peak_in into the snapshot; set index=0; set out_fid = previous value + 1 (first frame after reset is 1; wraps modulo 2^FID_W); go to STREAM.
  - Latency: out_valid is high on the first edge after the load edge.
- State STREAM:
  - out_valid=1, out_data=snapshot[index], out_pix_idx=index.
  - out_first=(index==0), out_last=(index==PIXEL_NUM-1).
  - Transfer with index<PIXEL_NUM-1: index increments.
  - Transfer on the last pixel: go to IDLE, busy falls on the next edge.
  - Throughput is 1 beat/cycle under continuous ready; a full frame takes PIXEL_NUM cycles.
- Load while busy=1, including the same cycle as the final transfer:
  - The load is ignored; the snapshot is not modified and out_fid does not increment.
  - overrun is set on the next edge.
- Load in IDLE is accepted even if it comes on the cycle right after the final transfer, so back-to-back frames have a 1-cycle gap.
- overrun:
  - Set by a dropped load; cleared by overrun_clr.
  - If set and clear happen in the same cycle, set wins.
- PIXEL_NUM=1: the only beat has out_first and out_last both high.
- Widths: the index counter is IDX_W wide and compared only against PIXEL_NUM-1 (or PIXEL_NUM with the option below); no value above that is ever reached.

Optional Feature:
- Macro: PEAK_READOUT_CHECKSUM_EN.
- Defined:
  - An extra state CSUM follows STREAM after the last pixel transfer.
  - It emits one beat with out_data = modulo-2^NP sum of all PIXEL_NUM snapshot peaks, out_pix_idx = PIXEL_NUM, out_first=0, out_last=1.
  - In this mode the last pixel beat has out_last=0.
  - The frame is PIXEL_NUM+1 beats; busy stays high through CSUM.
  - The sum is accumulated as pixel beats transfer, so a stalled CSUM beat holds a stable value.
- Undefined: no CSUM state, no accumulator, and the frame is PIXEL_NUM beats.

Decomposition:
- Shared package sifh_readout_pkg holds:
  - state enum {IDLE, STREAM, CSUM};
  - an index-width helper function;
  - default NP/PIXEL_NUM constants aligned with the parameters header.
- No sub-module is natural. The snapshot register bank, counter and FSM stay in one module of about 150–250 lines.

Test Plan (PIXEL_NUM=4, NP=12, FID_W=8 unless noted):
- Basic frame: peaks {0x010,0x020,0x030,0xFFF}, load at t0, out_ready=1 → beats at t0+1..t0+4 with idx 0..3; out_first at idx0, out_last at idx3; out_fid=1; busy low at t0+5.
- Backpressure: drop out_ready for 3 cycles at idx1 → idx1/0x020 held stable for 3 cycles, no skip or duplicate; 4 transfers total.
- Overrun: second load at idx2 with different peaks → streamed values unchanged, out_fid stays 1; overrun=1 until overrun_clr; a clear and a drop in the same cycle leave overrun=1.
- Back-to-back: load asserted the cycle after the final transfer → accepted, out_fid=2; a load coincident with the final transfer → dropped, overrun=1.
- Reset mid-stream: res low at idx2 → out_valid=0 immediately, all outputs 0; next load gives out_fid=1 and idx starts at 0.
- With PEAK_READOUT_CHECKSUM_EN: frame 1 peaks → 5 beats; 5th beat has idx=4, data=(0x010+0x020+0x030+0xFFF) mod 4096 = 0x05F, out_last only on beat 5.
